activation_unit_2ch: RTL and testbench
======================================

# activation_unit_2ch

Dual-channel spiking activation stage for the SNN datapath. Each channel compares a signed membrane potential, integrated upstream, against its own signed threshold. It emits a registered one-cycle spike flag and keeps a saturating count of spikes since reset. It sits between the neuron accumulators and the spike router/readout logic. Port list matches the `activation_unit_2` instance shape.

## Interface
Parameters:
- DATA_WIDTH, 16, width of threshold and membrane potential (two's complement)
- COUNT_WIDTH, 5, width of each spike counter

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset; one clock; reset is synchronous and active-high (rstn = 1 resets, sampled on rising clk edge)
- threshold_0  in  DATA_WIDTH  signed firing threshold, channel 0
- membrane_potential_0  in  DATA_WIDTH  signed membrane potential, channel 0
- threshold_1  in  DATA_WIDTH  signed firing threshold, channel 1
- membrane_potential_1  in  DATA_WIDTH  signed membrane potential, channel 1
- out_spike_0  out  1  registered spike, channel 0
- accumulated_spikes_0  out  COUNT_WIDTH  spike count, channel 0
- out_spike_1  out  1  registered spike, channel 1
- accumulated_spikes_1  out  COUNT_WIDTH  spike count, channel 1

## Operation
- Channels are identical and fully independent. There is no shared state.
- Fire condition: signed(membrane_potential_i) >= signed(threshold_i). Equality fires.
- Comparison is full-width signed. A negative potential with a positive threshold never fires. Both negative compare correctly, e.g. -5 >= -8 fires.
- Each clock edge with reset low:
  - out_spike_i <= fire_i.
  - If fire_i: accumulated_spikes_i <= accumulated_spikes_i + 1, saturating at 2^COUNT_WIDTH-1 (31). It holds at 31 and does not wrap.
  - Otherwise accumulated_spikes_i holds.
- No reset-on-fire or leak is performed here. That is upstream's job.
- Inputs are sampled every cycle. There is no valid/handshake; every cycle is a sample.

## Timing
- Latency 1 cycle: an input sampled at edge N produces out_spike_i and an updated count visible after edge N.
- out_spike_i is high for exactly the cycles whose preceding sample fired. Consecutive firing samples keep it high continuously.
- Reset (rstn = 1 at an edge): out_spike_0/1 = 0 and accumulated_spikes_0/1 = 0 after that edge. Inputs are ignored during reset.
- Reset mid-operation clears counts immediately at that edge. The first post-reset sample is taken at the first edge with rstn = 0.
- Outputs are pure registers. There is no combinational input-to-output path.

## Structure
- Shared package: DATA_WIDTH and COUNT_WIDTH defaults, plus a COUNT_MAX constant (all ones).
- Sub-module `activation_channel` holds the compare, spike register and saturating counter. Top instantiates it twice and only wires ports.

## Test plan
- Reset: hold rstn = 1 for 2 cycles with potentials above threshold -> all outputs 0 throughout.
- Threshold boundary (thr0 = 32): potential 31 -> no spike; 32 -> spike next cycle, count0 = 1; 33 -> spike, count0 = 2.
- Signed handling (thr1 = 16): potential -20 -> no spike. Then set thr1 = -8: potential -5 -> spike; potential -9 -> no spike.
- Saturation: hold potential0 = 63 above thr0 = 32 for 40 cycles -> count0 reaches 31 at cycle 31 and stays 31; out_spike_0 stays high.
- Independence: random potentials, ch0 in [-63, 63] and ch1 in [-31, 31], with thr0 = 32 and thr1 = 16, over 1000 cycles -> spikes and counts match a reference model per channel, with 1-cycle latency.
- Mid-run reset: after count1 = 7, pulse rstn = 1 for one edge -> count1 = 0 and out_spike_1 = 0 on that edge; counting resumes the next edge.

Source files
------------

// File: rtl/activation_unit_2ch_pkg.sv
// Shared widths and constants for the dual-channel spiking activation stage.
package activation_unit_2ch_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int COUNT_WIDTH = 5;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
endpackage

// File: rtl/activation_unit_2ch_channel.sv
// One activation channel: signed threshold compare, registered spike, saturating spike count.
// Latency 1 cycle; no handshake, every cycle is a sample.
module activation_channel
    import activation_unit_2ch_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int CW = COUNT_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] threshold_i,
    input  logic [DW-1:0] potential_i,
    output logic          spike_o,
    output logic [CW-1:0] count_o
);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          fire;
    logic          spike_d, spike_q;
    logic [CW-1:0] count_d, count_q;

    always_comb begin
        fire    = $signed(potential_i) >= $signed(threshold_i);
        spike_d = fire;
        count_d = count_q;
        // Saturate rather than wrap so readout never sees a false low count.
        if (fire && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spike_q <= 1'b0;
            count_q <= '0;
        end else begin
            spike_q <= spike_d;
            count_q <= count_d;
        end
    end

    assign spike_o = spike_q;
    assign count_o = count_q;
endmodule

// File: rtl/activation_unit_2ch.sv
// Dual-channel spiking activation stage; two independent channels, wiring only.
// Note: rstn is active-high despite its name, kept for drop-in port compatibility.
module activation_unit_2ch
    import activation_unit_2ch_pkg::*;
#(
    parameter int DATA_WIDTH  = activation_unit_2ch_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = activation_unit_2ch_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DATA_WIDTH-1:0]  threshold_0,
    input  logic [DATA_WIDTH-1:0]  membrane_potential_0,
    input  logic [DATA_WIDTH-1:0]  threshold_1,
    input  logic [DATA_WIDTH-1:0]  membrane_potential_1,
    output logic                   out_spike_0,
    output logic [COUNT_WIDTH-1:0] accumulated_spikes_0,
    output logic                   out_spike_1,
    output logic [COUNT_WIDTH-1:0] accumulated_spikes_1
);
    activation_channel #(.DW(DATA_WIDTH), .CW(COUNT_WIDTH)) u_ch0 (
        .clk_i       (clk),
        .rst_i       (rstn),
        .threshold_i (threshold_0),
        .potential_i (membrane_potential_0),
        .spike_o     (out_spike_0),
        .count_o     (accumulated_spikes_0)
    );

    activation_channel #(.DW(DATA_WIDTH), .CW(COUNT_WIDTH)) u_ch1 (
        .clk_i       (clk),
        .rst_i       (rstn),
        .threshold_i (threshold_1),
        .potential_i (membrane_potential_1),
        .spike_o     (out_spike_1),
        .count_o     (accumulated_spikes_1)
    );
endmodule

// File: tb/tb_activation_unit_2ch.sv
// Directed self-checking bench for activation_unit_2ch.
module tb_activation_unit_2ch;
    import activation_unit_2ch_pkg::*;

    logic                   clk;
    logic                   rstn;
    logic [DATA_WIDTH-1:0]  thr0, pot0, thr1, pot1;
    logic                   spk0, spk1;
    logic [COUNT_WIDTH-1:0] cnt0, cnt1;

    int checks;
    int errors;

    activation_unit_2ch dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .threshold_0          (thr0),
        .membrane_potential_0 (pot0),
        .threshold_1          (thr1),
        .membrane_potential_1 (pot1),
        .out_spike_0          (spk0),
        .accumulated_spikes_0 (cnt0),
        .out_spike_1          (spk1),
        .accumulated_spikes_1 (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        thr0 = 16'(32);  pot0 = 16'(63);
        thr1 = 16'(16);  pot1 = 16'(31);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks += 4;
            if (spk0 !== 1'b0) begin errors++; $display("FAIL reset_spk0 cyc%0d got %b want 0", i, spk0); end
            if (spk1 !== 1'b0) begin errors++; $display("FAIL reset_spk1 cyc%0d got %b want 0", i, spk1); end
            if (cnt0 !== 5'd0) begin errors++; $display("FAIL reset_cnt0 cyc%0d got %0d want 0", i, cnt0); end
            if (cnt1 !== 5'd0) begin errors++; $display("FAIL reset_cnt1 cyc%0d got %0d want 0", i, cnt1); end
        end
    endtask

    task automatic test_threshold();
        logic [DATA_WIDTH-1:0] pots [3];
        logic                  exp_s [3];
        logic [4:0]            exp_c [3];
        pots  = '{16'(31), 16'(32), 16'(33)};
        exp_s = '{1'b0, 1'b1, 1'b1};
        exp_c = '{5'd0, 5'd1, 5'd2};
        rstn = 1'b0;
        thr0 = 16'(32);
        thr1 = 16'(16); pot1 = 16'(0);
        for (int i = 0; i < 3; i++) begin
            pot0 = pots[i];
            tick();
            checks += 3;
            if (spk0 !== exp_s[i]) begin errors++; $display("FAIL thr_spk0 pot=%0d got %b want %b", $signed(pots[i]), spk0, exp_s[i]); end
            if (cnt0 !== exp_c[i]) begin errors++; $display("FAIL thr_cnt0 pot=%0d got %0d want %0d", $signed(pots[i]), cnt0, exp_c[i]); end
            if (cnt1 !== 5'd0)     begin errors++; $display("FAIL thr_cnt1_idle got %0d want 0", cnt1); end
        end
    endtask

    task automatic test_signed();
        logic [DATA_WIDTH-1:0] thrs [3];
        logic [DATA_WIDTH-1:0] pots [3];
        logic                  exp_s [3];
        logic [4:0]            exp_c [3];
        thrs  = '{16'(16), 16'(-8), 16'(-8)};
        pots  = '{16'(-20), 16'(-5), 16'(-9)};
        exp_s = '{1'b0, 1'b1, 1'b0};
        exp_c = '{5'd0, 5'd1, 5'd1};
        pot0 = 16'(0);
        for (int i = 0; i < 3; i++) begin
            thr1 = thrs[i];
            pot1 = pots[i];
            tick();
            checks += 3;
            if (spk1 !== exp_s[i]) begin errors++; $display("FAIL sign_spk1 step%0d got %b want %b", i, spk1, exp_s[i]); end
            if (cnt1 !== exp_c[i]) begin errors++; $display("FAIL sign_cnt1 step%0d got %0d want %0d", i, cnt1, exp_c[i]); end
            if (cnt0 !== 5'd2)     begin errors++; $display("FAIL sign_cnt0_hold step%0d got %0d want 2", i, cnt0); end
        end
    endtask

    task automatic test_saturation();
        logic [4:0] exp_c;
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        thr0 = 16'(32); pot0 = 16'(63);
        thr1 = 16'(16); pot1 = 16'(0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_c = (k >= 31) ? COUNT_MAX : 5'(k);
            checks += 3;
            if (spk0 !== 1'b1)  begin errors++; $display("FAIL sat_spk0 cyc%0d got %b want 1", k, spk0); end
            if (cnt0 !== exp_c) begin errors++; $display("FAIL sat_cnt0 cyc%0d got %0d want %0d", k, cnt0, exp_c); end
            if (cnt1 !== 5'd0)  begin errors++; $display("FAIL sat_cnt1_idle cyc%0d got %0d want 0", k, cnt1); end
        end
    endtask

    task automatic test_mid_reset();
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        thr1 = 16'(16); pot1 = 16'(20);
        thr0 = 16'(32); pot0 = 16'(0);
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (cnt1 !== 5'd7) begin errors++; $display("FAIL mid_pre_cnt1 got %0d want 7", cnt1); end
        rstn = 1'b1;
        tick();
        checks += 2;
        if (cnt1 !== 5'd0) begin errors++; $display("FAIL mid_rst_cnt1 got %0d want 0", cnt1); end
        if (spk1 !== 1'b0) begin errors++; $display("FAIL mid_rst_spk1 got %b want 0", spk1); end
        rstn = 1'b0;
        tick();
        checks += 2;
        if (cnt1 !== 5'd1) begin errors++; $display("FAIL mid_resume_cnt1 got %0d want 1", cnt1); end
        if (spk1 !== 1'b1) begin errors++; $display("FAIL mid_resume_spk1 got %b want 1", spk1); end
    endtask

    task automatic test_random();
        int  p0, p1;
        int  m_c0, m_c1;
        logic m_s0, m_s1;
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        thr0 = 16'(32);
        thr1 = 16'(16);
        m_c0 = 0; m_c1 = 0;
        for (int i = 0; i < 1000; i++) begin
            p0 = int'($urandom_range(0, 126)) - 63;
            p1 = int'($urandom_range(0, 62)) - 31;
            pot0 = 16'(p0);
            pot1 = 16'(p1);
            m_s0 = (p0 >= 32);
            m_s1 = (p1 >= 16);
            if (m_s0 && m_c0 < 31) m_c0++;
            if (m_s1 && m_c1 < 31) m_c1++;
            tick();
            checks += 4;
            if (spk0 !== m_s0)      begin errors++; $display("FAIL rnd_spk0 i=%0d p0=%0d got %b want %b", i, p0, spk0, m_s0); end
            if (spk1 !== m_s1)      begin errors++; $display("FAIL rnd_spk1 i=%0d p1=%0d got %b want %b", i, p1, spk1, m_s1); end
            if (cnt0 !== 5'(m_c0))  begin errors++; $display("FAIL rnd_cnt0 i=%0d got %0d want %0d", i, cnt0, m_c0); end
            if (cnt1 !== 5'(m_c1))  begin errors++; $display("FAIL rnd_cnt1 i=%0d got %0d want %0d", i, cnt1, m_c1); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b1;
        thr0 = '0; pot0 = '0; thr1 = '0; pot1 = '0;
        test_reset();
        test_threshold();
        test_signed();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
